bram_arbiter: RTL and testbench

//  Shares the single BRAM memory port between the instruction-fetch (I) and data (D) requesters of the CPU.

---
 rtl/bram_arbiter_if.sv | 44 ++++
 rtl/bram_arbiter.sv | 172 +++++++++++++++++
 tb/tb_bram_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_arbiter_if.sv
// Bus bundle between the CPU requesters (I fetch, D data), the arbiter and the
// BRAM access block. The arbiter uses the slave view; the core/memory side
// (or a testbench standing in for both) uses the master view.
interface bram_arbiter_if #(
  parameter int ADDR_W = 15
);
  // instruction-fetch requester
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_ack;
  // data requester
  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_strb;
  logic              d_ack;
  // response shared by both requesters
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  // memory port
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic [3:0]        m_strb;
  logic              m_done;
  logic [31:0]       m_rdata;
  logic              m_err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_strb,
    input  m_done, m_rdata, m_err,
    output i_ack, d_ack, rsp_rdata, rsp_err,
    output m_req, m_we, m_addr, m_wdata, m_strb
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_strb,
    output m_done, m_rdata, m_err,
    input  i_ack, d_ack, rsp_rdata, rsp_err,
    input  m_req, m_we, m_addr, m_wdata, m_strb
  );
endinterface

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one BRAM port between instruction fetch (I) and
// data (D). One transaction in flight at a time; a memory access that never
// completes is closed with an error after TIMEOUT cycles.
module bram_arbiter #(
  parameter int ADDR_W  = 15,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          reset,
  bram_arbiter_if.slave bus
);

  localparam int            TW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic              grant_s;       // a requester wins this cycle (IDLE only)
  logic              grant_d_s;     // the winner is D
  logic              timeout_s;     // WAIT expired without m_done
  // Last winner; while a transaction is open it also names its owner.
  logic              last_d_r;
  logic [TW-1:0]     timer_r;

  logic              i_ack_r;
  logic              d_ack_r;
  logic [31:0]       rsp_rdata_r;
  logic              rsp_err_r;
  logic              m_req_r;
  logic              m_we_r;
  logic [ADDR_W-1:0] m_addr_r;
  logic [31:0]       m_wdata_r;
  logic [3:0]        m_strb_r;

  assign bus.i_ack     = i_ack_r;
  assign bus.d_ack     = d_ack_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.m_req     = m_req_r;
  assign bus.m_we      = m_we_r;
  assign bus.m_addr    = m_addr_r;
  assign bus.m_wdata   = m_wdata_r;
  assign bus.m_strb    = m_strb_r;

  // Next-state and arbitration decision.
  always_comb begin
    state_next_s = state_r;
    grant_s      = 1'b0;
    grant_d_s    = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.i_req && bus.d_req) begin
          grant_s      = 1'b1;
          grant_d_s    = ~last_d_r;
          state_next_s = S_ISSUE;
        end else if (bus.i_req) begin
          grant_s      = 1'b1;
          grant_d_s    = 1'b0;
          state_next_s = S_ISSUE;
        end else if (bus.d_req) begin
          grant_s      = 1'b1;
          grant_d_s    = 1'b1;
          state_next_s = S_ISSUE;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_next_s = S_WAIT;
      end
      S_WAIT: begin
        if (bus.m_done) begin
          state_next_s = S_RESP;
        end else if (timer_r == T_LAST) begin
          timeout_s    = 1'b1;
          state_next_s = S_RESP;
        end else begin
          state_next_s = S_WAIT;
        end
      end
      S_RESP: begin
        state_next_s = S_IDLE;
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Latched memory command, timeout timer and registered responses/acks.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_d_r    <= 1'b1;
      timer_r     <= '0;
      i_ack_r     <= 1'b0;
      d_ack_r     <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
      m_req_r     <= 1'b0;
      m_we_r      <= 1'b0;
      m_addr_r    <= '0;
      m_wdata_r   <= 32'h0000_0000;
      m_strb_r    <= 4'b0000;
    end else begin
      i_ack_r <= 1'b0;
      d_ack_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (grant_s) begin
            last_d_r <= grant_d_s;
            if (grant_d_s) begin
              m_we_r    <= bus.d_we;
              m_addr_r  <= bus.d_addr[ADDR_W-1:0];
              m_wdata_r <= bus.d_wdata;
              m_strb_r  <= bus.d_we ? bus.d_strb : 4'b0000;
            end else begin
              m_we_r    <= 1'b0;
              m_addr_r  <= bus.i_addr[ADDR_W-1:0];
              m_wdata_r <= 32'h0000_0000;
              m_strb_r  <= 4'b0000;
            end
          end
        end
        S_ISSUE: begin
          m_req_r <= 1'b1;
          timer_r <= '0;
        end
        S_WAIT: begin
          if (bus.m_done) begin
            m_req_r     <= 1'b0;
            rsp_rdata_r <= m_we_r ? 32'h0000_0000 : bus.m_rdata;
            rsp_err_r   <= bus.m_err;
            i_ack_r     <= ~last_d_r;
            d_ack_r     <= last_d_r;
          end else if (timeout_s) begin
            m_req_r     <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b1;
            i_ack_r     <= ~last_d_r;
            d_ack_r     <= last_d_r;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        S_RESP: begin
          timer_r <= '0;
        end
        default: begin
          timer_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter: directed scenarios plus randomized
// request traffic against a transaction-level round-robin model and a
// behavioural memory responder.
module tb_bram_arbiter;

  typedef struct {
    logic [14:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } mreq_t;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  // memory responder controls and logs
  int          mem_lat;
  bit          mem_mute;
  bit          mem_err_cfg;
  bit          mem_use_force;
  bit          stray_done;
  logic [31:0] mem_force;
  mreq_t       mlog[$];
  logic [31:0] rd_q[$];
  logic        er_q[$];

  // model: last granted requester was D
  bit model_last_d;

  bram_arbiter_if #(.ADDR_W(15)) bus ();

  bram_arbiter #(.ADDR_W(15), .TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory side: logs each new m_req and answers after mem_lat cycles.
  initial begin : mem_model
    bit seen;
    int cnt;
    seen = 1'b0;
    cnt  = -1;
    bus.m_done  = 1'b0;
    bus.m_rdata = 32'h0;
    bus.m_err   = 1'b0;
    forever begin
      @(negedge clk);
      bus.m_done = 1'b0;
      if (!bus.m_req) begin
        seen = 1'b0;
      end else begin
        if (!seen) begin
          seen = 1'b1;
          cnt  = mem_lat;
          mlog.push_back(mreq_t'{bus.m_addr, bus.m_we, bus.m_wdata, bus.m_strb});
        end
        if (!mem_mute && cnt == 0) begin
          bus.m_done  = 1'b1;
          bus.m_rdata = mem_use_force ? mem_force : $urandom;
          bus.m_err   = mem_err_cfg;
          rd_q.push_back(bus.m_rdata);
          er_q.push_back(bus.m_err);
          cnt = -1;
        end else if (!mem_mute && cnt > 0) begin
          cnt--;
        end
      end
      if (stray_done) begin
        bus.m_done  = 1'b1;
        bus.m_rdata = $urandom;
        bus.m_err   = 1'b1;
      end
    end
  end

  task automatic clear_logs();
    mlog.delete();
    rd_q.delete();
    er_q.delete();
  endtask

  // Waits (bounded) for either ack; returns what was seen.
  task automatic wait_ack(output bit gi, output bit gd, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(bus.i_ack || bus.d_ack) && cyc < 200);
    gi = bus.i_ack;
    gd = bus.d_ack;
  endtask

  // Waits (bounded) for m_req to rise; returns negedges elapsed.
  task automatic wait_mreq(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.m_req && cyc < 200);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    model_last_d = 1'b1;
    vectors++; if (bus.i_ack !== 1'b0) begin miscompares++; $display("FAIL reset_i_ack got %0h want 0", bus.i_ack); end
    vectors++; if (bus.d_ack !== 1'b0) begin miscompares++; $display("FAIL reset_d_ack got %0h want 0", bus.d_ack); end
    vectors++; if (bus.rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_err got %0h want 0", bus.rsp_err); end
    vectors++; if (bus.m_req !== 1'b0) begin miscompares++; $display("FAIL reset_m_req got %0h want 0", bus.m_req); end
    vectors++; if (bus.m_we !== 1'b0) begin miscompares++; $display("FAIL reset_m_we got %0h want 0", bus.m_we); end
    vectors++; if (bus.rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rsp_rdata got %0h want 0", bus.rsp_rdata); end
    vectors++; if (bus.m_addr !== 15'h0) begin miscompares++; $display("FAIL reset_m_addr got %0h want 0", bus.m_addr); end
    vectors++; if (bus.m_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_m_wdata got %0h want 0", bus.m_wdata); end
    vectors++; if (bus.m_strb !== 4'h0) begin miscompares++; $display("FAIL reset_m_strb got %0h want 0", bus.m_strb); end
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    bit gi, gd;
    int cyc;
    clear_logs();
    mem_lat = 3; mem_err_cfg = 1'b0; mem_use_force = 1'b1; mem_force = 32'h1234_5678;
    @(negedge clk);
    bus.i_addr = 32'h0000_8004;
    bus.i_req  = 1'b1;
    wait_mreq(cyc);
    vectors++; if (cyc !== 2) begin miscompares++; $display("FAIL fetch_latency got %0d want 2", cyc); end
    vectors++; if (bus.m_addr !== 15'h0004) begin miscompares++; $display("FAIL fetch_m_addr got %0h want 4", bus.m_addr); end
    vectors++; if (bus.m_strb !== 4'h0) begin miscompares++; $display("FAIL fetch_m_strb got %0h want 0", bus.m_strb); end
    vectors++; if (bus.m_we !== 1'b0) begin miscompares++; $display("FAIL fetch_m_we got %0h want 0", bus.m_we); end
    wait_ack(gi, gd, cyc);
    bus.i_req = 1'b0;
    model_last_d = 1'b0;
    vectors++; if ({gi, gd} !== 2'b10) begin miscompares++; $display("FAIL fetch_ack got i=%0b d=%0b want i=1 d=0", gi, gd); end
    vectors++; if (bus.rsp_rdata !== 32'h1234_5678) begin miscompares++; $display("FAIL fetch_rdata got %0h want 12345678", bus.rsp_rdata); end
    vectors++; if (bus.rsp_err !== 1'b0) begin miscompares++; $display("FAIL fetch_err got %0h want 0", bus.rsp_err); end
    @(negedge clk);
    vectors++; if (bus.i_ack !== 1'b0) begin miscompares++; $display("FAIL fetch_ack_width got %0h want 0", bus.i_ack); end
    mem_use_force = 1'b0;
  endtask

  task automatic test_write();
    bit gi, gd;
    int cyc;
    clear_logs();
    mem_lat = 2; mem_err_cfg = 1'b0;
    @(negedge clk);
    bus.d_addr = 32'h0000_0010; bus.d_we = 1'b1; bus.d_wdata = 32'hDEAD_BEEF; bus.d_strb = 4'b0011;
    bus.d_req  = 1'b1;
    wait_mreq(cyc);
    vectors++; if (bus.m_we !== 1'b1) begin miscompares++; $display("FAIL write_m_we got %0h want 1", bus.m_we); end
    vectors++; if (bus.m_wdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL write_m_wdata got %0h want deadbeef", bus.m_wdata); end
    vectors++; if (bus.m_strb !== 4'b0011) begin miscompares++; $display("FAIL write_m_strb got %0h want 3", bus.m_strb); end
    vectors++; if (bus.m_addr !== 15'h0010) begin miscompares++; $display("FAIL write_m_addr got %0h want 10", bus.m_addr); end
    wait_ack(gi, gd, cyc);
    bus.d_req = 1'b0;
    model_last_d = 1'b1;
    vectors++; if ({gi, gd} !== 2'b01) begin miscompares++; $display("FAIL write_ack got i=%0b d=%0b want i=0 d=1", gi, gd); end
    vectors++; if (bus.rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL write_rdata got %0h want 0", bus.rsp_rdata); end
    vectors++; if (bus.rsp_err !== 1'b0) begin miscompares++; $display("FAIL write_err got %0h want 0", bus.rsp_err); end
    @(negedge clk);
    vectors++; if (bus.d_ack !== 1'b0) begin miscompares++; $display("FAIL write_ack_width got %0h want 0", bus.d_ack); end
  endtask

  task automatic test_err_read();
    bit gi, gd;
    int cyc;
    logic [31:0] rd;
    clear_logs();
    mem_lat = 1; mem_err_cfg = 1'b1;
    @(negedge clk);
    bus.d_addr = $urandom; bus.d_we = 1'b0; bus.d_wdata = $urandom; bus.d_strb = 4'b1111;
    bus.d_req  = 1'b1;
    wait_ack(gi, gd, cyc);
    bus.d_req = 1'b0;
    model_last_d = 1'b1;
    rd = (rd_q.size() > 0) ? rd_q[0] : 32'hxxxx_xxxx;
    vectors++; if ({gi, gd} !== 2'b01) begin miscompares++; $display("FAIL errrd_ack got i=%0b d=%0b want i=0 d=1", gi, gd); end
    vectors++; if (bus.rsp_err !== 1'b1) begin miscompares++; $display("FAIL errrd_err got %0h want 1", bus.rsp_err); end
    vectors++; if (bus.rsp_rdata !== rd) begin miscompares++; $display("FAIL errrd_rdata got %0h want %0h", bus.rsp_rdata, rd); end
    vectors++; if (mlog.size() == 0 || mlog[0].strb !== 4'h0) begin miscompares++; $display("FAIL errrd_m_strb logged=%0d want strb 0", mlog.size()); end
    mem_err_cfg = 1'b0;
  endtask

  task automatic test_timeout();
    int cyc, hi;
    clear_logs();
    mem_mute = 1'b1;
    @(negedge clk);
    bus.i_addr = $urandom;
    bus.i_req  = 1'b1;
    wait_mreq(cyc);
    hi = 0;
    while (bus.m_req && hi < 100) begin
      hi++;
      @(negedge clk);
    end
    bus.i_req = 1'b0;
    model_last_d = 1'b0;
    vectors++; if (hi !== 16) begin miscompares++; $display("FAIL timeout_len got %0d want 16", hi); end
    vectors++; if (bus.i_ack !== 1'b1) begin miscompares++; $display("FAIL timeout_ack got %0h want 1", bus.i_ack); end
    vectors++; if (bus.rsp_err !== 1'b1) begin miscompares++; $display("FAIL timeout_err got %0h want 1", bus.rsp_err); end
    vectors++; if (bus.rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL timeout_rdata got %0h want 0", bus.rsp_rdata); end
    mem_mute = 1'b0;
  endtask

  task automatic test_stray_done();
    int seen;
    @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.i_ack || bus.d_ack || bus.m_req) seen++;
    end
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL stray_done activity got %0d want 0", seen); end
  endtask

  task automatic test_reset_mid();
    bit gi, gd;
    int cyc, acks;
    clear_logs();
    mem_mute = 1'b1;
    @(negedge clk);
    bus.i_addr = $urandom;
    bus.i_req  = 1'b1;
    wait_mreq(cyc);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++; if (bus.m_req !== 1'b0) begin miscompares++; $display("FAIL rstmid_m_req got %0h want 0", bus.m_req); end
    bus.i_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_last_d = 1'b1;
    mem_mute = 1'b0;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.i_ack || bus.d_ack) acks++;
    end
    vectors++; if (acks !== 0) begin miscompares++; $display("FAIL rstmid_no_ack got %0d want 0", acks); end
    clear_logs();
    mem_lat = 1;
    bus.i_addr = $urandom; bus.d_addr = $urandom; bus.d_we = 1'b0;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    wait_ack(gi, gd, cyc);
    bus.i_req = 1'b0;
    vectors++; if ({gi, gd} !== 2'b10) begin miscompares++; $display("FAIL rstmid_first got i=%0b d=%0b want i=1 d=0", gi, gd); end
    wait_ack(gi, gd, cyc);
    bus.d_req = 1'b0;
    model_last_d = 1'b1;
    vectors++; if ({gi, gd} !== 2'b01) begin miscompares++; $display("FAIL rstmid_second got i=%0b d=%0b want i=0 d=1", gi, gd); end
  endtask

  // Request traffic; requests only change at ack points so the model knows
  // exactly which requesters compete at each grant.
  task automatic test_traffic(input int n, input bit both_held, input string tag);
    bit pi, pd, gi, gd, exp_d;
    int cyc, done_n, r;
    mreq_t m;
    logic [31:0] rd;
    logic er, ewe;
    logic [14:0] ea;
    logic [3:0] es;
    clear_logs();
    @(negedge clk);
    if (both_held) begin
      pi = 1'b1; pd = 1'b1;
    end else begin
      r = $urandom_range(1, 3); pi = r[0]; pd = r[1];
    end
    bus.i_addr = $urandom; bus.d_addr = $urandom; bus.d_wdata = $urandom;
    bus.d_we = 1'($urandom_range(0, 1)); bus.d_strb = 4'($urandom_range(0, 15));
    done_n = 0;
    while (pi || pd) begin
      bus.i_req = pi;
      bus.d_req = pd;
      mem_lat = $urandom_range(0, 4);
      mem_err_cfg = ($urandom_range(0, 3) == 0);
      exp_d = (pi && pd) ? !model_last_d : pd;
      model_last_d = exp_d;
      wait_ack(gi, gd, cyc);
      done_n++;
      vectors++;
      if ({gi, gd} !== {!exp_d, exp_d}) begin
        miscompares++;
        $display("FAIL %s_winner txn %0d got i=%0b d=%0b want i=%0b d=%0b", tag, done_n, gi, gd, !exp_d, exp_d);
      end
      if (exp_d) begin
        ea = bus.d_addr[14:0]; ewe = bus.d_we; es = bus.d_we ? bus.d_strb : 4'b0000;
      end else begin
        ea = bus.i_addr[14:0]; ewe = 1'b0; es = 4'b0000;
      end
      vectors++;
      if (mlog.size() != 1 || rd_q.size() != 1) begin
        miscompares++;
        $display("FAIL %s_mem_count txn %0d got req=%0d rsp=%0d want 1", tag, done_n, mlog.size(), rd_q.size());
        clear_logs();
      end else begin
        m = mlog.pop_front(); rd = rd_q.pop_front(); er = er_q.pop_front();
        vectors++; if (m.addr !== ea) begin miscompares++; $display("FAIL %s_m_addr txn %0d got %0h want %0h", tag, done_n, m.addr, ea); end
        vectors++; if (m.we !== ewe) begin miscompares++; $display("FAIL %s_m_we txn %0d got %0h want %0h", tag, done_n, m.we, ewe); end
        vectors++; if (m.strb !== es) begin miscompares++; $display("FAIL %s_m_strb txn %0d got %0h want %0h", tag, done_n, m.strb, es); end
        if (ewe) begin
          vectors++; if (m.wdata !== bus.d_wdata) begin miscompares++; $display("FAIL %s_m_wdata txn %0d got %0h want %0h", tag, done_n, m.wdata, bus.d_wdata); end
        end
        vectors++; if (bus.rsp_rdata !== (ewe ? 32'h0 : rd)) begin miscompares++; $display("FAIL %s_rdata txn %0d got %0h want %0h", tag, done_n, bus.rsp_rdata, (ewe ? 32'h0 : rd)); end
        vectors++; if (bus.rsp_err !== er) begin miscompares++; $display("FAIL %s_err txn %0d got %0h want %0h", tag, done_n, bus.rsp_err, er); end
      end
      if (exp_d) begin
        pd = (done_n < n) && (both_held || ($urandom_range(0, 1) == 1));
        if (pd) begin
          bus.d_addr = $urandom; bus.d_wdata = $urandom;
          bus.d_we = 1'($urandom_range(0, 1)); bus.d_strb = 4'($urandom_range(0, 15));
        end
      end else begin
        pi = (done_n < n) && (both_held || ($urandom_range(0, 1) == 1));
        if (pi) bus.i_addr = $urandom;
      end
      if (!pi && !pd && done_n < n) begin
        r = $urandom_range(1, 3); pi = r[0]; pd = r[1];
        bus.i_addr = $urandom; bus.d_addr = $urandom; bus.d_wdata = $urandom;
        bus.d_we = 1'($urandom_range(0, 1)); bus.d_strb = 4'($urandom_range(0, 15));
      end
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    mem_lat = 0; mem_mute = 1'b0; mem_err_cfg = 1'b0; mem_use_force = 1'b0;
    stray_done = 1'b0; mem_force = 32'h0; model_last_d = 1'b1;
    reset = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0; bus.d_strb = 4'h0;
    test_reset();
    test_fetch();
    test_write();
    test_err_read();
    test_timeout();
    test_stray_done();
    test_reset_mid();
    test_traffic(6, 1'b1, "fair");
    test_traffic(40, 1'b0, "rand");
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
